// File: rtl/serial_adder_if.sv
// Handshake and operand/result bundle for the digit-serial adder/subtractor.
interface serial_adder_if #(
    parameter int BITS = 8
) ();
    logic            i_start;
    logic            i_subtract;
    logic            i_carry;
    logic [BITS-1:0] i_augend;
    logic [BITS-1:0] i_addend;
    logic            o_busy;
    logic            o_done;
    logic [BITS-1:0] o_sum;
    logic            o_carry;
    logic            o_overflow;

    modport master (
        output i_start, i_subtract, i_carry, i_augend, i_addend,
        input  o_busy, o_done, o_sum, o_carry, o_overflow
    );

    modport slave (
        input  i_start, i_subtract, i_carry, i_augend, i_addend,
        output o_busy, o_done, o_sum, o_carry, o_overflow
    );
endinterface

// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: DIGIT bits per clock, LSB first.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for i_start; results hold their last values
// RUN   | one digit per edge; the edge for digit N-1 loads results
module serial_adder #(
    parameter int BITS  = 8,
    parameter int DIGIT = 1
) (
    input logic           i_clock,
    input logic           i_reset_n,
    serial_adder_if.slave bus
);
    localparam int N  = BITS / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    if ((BITS % DIGIT) != 0) begin : g_bad_digit
        $error("serial_adder: BITS must be a multiple of DIGIT");
    end

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state;
    state_t          state_next;
    logic            load;
    logic            step;
    logic            last;

    logic [BITS-1:0] a;
    logic [BITS-1:0] b;
    logic [BITS-1:0] a_sh;
    logic [BITS-1:0] b_sh;
    logic [BITS-1:0] b_in;
    logic [BITS-1:0] acc;
    logic [BITS-1:0] acc_next;
    logic            cy;
    logic [CW-1:0]   cnt;
    logic            a_msb;
    logic            b_msb;
    logic [DIGIT:0]  digit_sum;

    logic [BITS-1:0] sum_q;
    logic            carry_q;
    logic            ovf_q;
    logic            done_q;

    assign b_in = bus.i_subtract ? ~bus.i_addend : bus.i_addend;

    // One digit of the ripple: low DIGIT bits of both operands plus the carry register.
    always_comb begin
        digit_sum = {1'b0, a[DIGIT-1:0]} + {1'b0, b[DIGIT-1:0]} + {{DIGIT{1'b0}}, cy};
    end

    // With a single digit there is nothing left to shift, so the slices would be empty.
    if (DIGIT == BITS) begin : g_one_digit
        assign acc_next = digit_sum[DIGIT-1:0];
        assign a_sh     = '0;
        assign b_sh     = '0;
    end else begin : g_multi_digit
        assign acc_next = {digit_sum[DIGIT-1:0], acc[BITS-1:DIGIT]};
        assign a_sh     = {{DIGIT{1'b0}}, a[BITS-1:DIGIT]};
        assign b_sh     = {{DIGIT{1'b0}}, b[BITS-1:DIGIT]};
    end

    // Next-state and datapath strobes.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        last       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.i_start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (cnt == CW'(N - 1)) begin
                    last       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Operand latch, digit shift and result capture on the final digit.
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            a       <= '0;
            b       <= '0;
            acc     <= '0;
            cy      <= 1'b0;
            cnt     <= '0;
            a_msb   <= 1'b0;
            b_msb   <= 1'b0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (load) begin
                a     <= bus.i_augend;
                b     <= b_in;
                cy    <= bus.i_subtract ? ~bus.i_carry : bus.i_carry;
                cnt   <= '0;
                a_msb <= bus.i_augend[BITS-1];
                b_msb <= b_in[BITS-1];
            end else if (step) begin
                acc <= acc_next;
                a   <= a_sh;
                b   <= b_sh;
                cy  <= digit_sum[DIGIT];
                cnt <= cnt + CW'(1);
                if (last) begin
                    sum_q   <= acc_next;
                    carry_q <= digit_sum[DIGIT];
                    ovf_q   <= (a_msb == b_msb) && (acc_next[BITS-1] != a_msb);
                    done_q  <= 1'b1;
                end
            end
        end
    end

    assign bus.o_busy     = (state == RUN);
    assign bus.o_done     = done_q;
    assign bus.o_sum      = sum_q;
    assign bus.o_carry    = carry_q;
    assign bus.o_overflow = ovf_q;
endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: 8-bit with DIGIT 1 and 4, 4-bit sweep with DIGIT 1, 2, 4.
module tb_serial_adder;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic       s8_start, s8_sub, s8_cin;
    logic [7:0] s8_x, s8_y;
    logic       s4_start, s4_sub, s4_cin;
    logic [3:0] s4_x, s4_y;

    serial_adder_if #(.BITS(8)) bus8a ();
    serial_adder_if #(.BITS(8)) bus8b ();
    serial_adder_if #(.BITS(4)) bus4_1 ();
    serial_adder_if #(.BITS(4)) bus4_2 ();
    serial_adder_if #(.BITS(4)) bus4_4 ();

    assign bus8a.i_start    = s8_start;
    assign bus8a.i_subtract = s8_sub;
    assign bus8a.i_carry    = s8_cin;
    assign bus8a.i_augend   = s8_x;
    assign bus8a.i_addend   = s8_y;
    assign bus8b.i_start    = s8_start;
    assign bus8b.i_subtract = s8_sub;
    assign bus8b.i_carry    = s8_cin;
    assign bus8b.i_augend   = s8_x;
    assign bus8b.i_addend   = s8_y;
    assign bus4_1.i_start    = s4_start;
    assign bus4_1.i_subtract = s4_sub;
    assign bus4_1.i_carry    = s4_cin;
    assign bus4_1.i_augend   = s4_x;
    assign bus4_1.i_addend   = s4_y;
    assign bus4_2.i_start    = s4_start;
    assign bus4_2.i_subtract = s4_sub;
    assign bus4_2.i_carry    = s4_cin;
    assign bus4_2.i_augend   = s4_x;
    assign bus4_2.i_addend   = s4_y;
    assign bus4_4.i_start    = s4_start;
    assign bus4_4.i_subtract = s4_sub;
    assign bus4_4.i_carry    = s4_cin;
    assign bus4_4.i_augend   = s4_x;
    assign bus4_4.i_addend   = s4_y;

    serial_adder #(.BITS(8), .DIGIT(1)) dut8a (.i_clock(clk), .i_reset_n(rst_n), .bus(bus8a));
    serial_adder #(.BITS(8), .DIGIT(4)) dut8b (.i_clock(clk), .i_reset_n(rst_n), .bus(bus8b));
    serial_adder #(.BITS(4), .DIGIT(1)) dut4_1 (.i_clock(clk), .i_reset_n(rst_n), .bus(bus4_1));
    serial_adder #(.BITS(4), .DIGIT(2)) dut4_2 (.i_clock(clk), .i_reset_n(rst_n), .bus(bus4_2));
    serial_adder #(.BITS(4), .DIGIT(4)) dut4_4 (.i_clock(clk), .i_reset_n(rst_n), .bus(bus4_4));

    // sel8 picks which 8-bit DUT the run8 task observes (0: DIGIT=1, 1: DIGIT=4)
    logic       sel8 = 1'b0;
    wire        done8 = sel8 ? bus8b.o_done     : bus8a.o_done;
    wire        busy8 = sel8 ? bus8b.o_busy     : bus8a.o_busy;
    wire [7:0]  sum8  = sel8 ? bus8b.o_sum      : bus8a.o_sum;
    wire        c8    = sel8 ? bus8b.o_carry    : bus8a.o_carry;
    wire        v8    = sel8 ? bus8b.o_overflow : bus8a.o_overflow;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle8();
        int k = 0;
        while ((bus8a.o_busy || bus8b.o_busy || bus8a.o_done || bus8b.o_done) && k < 40) begin
            step();
            k++;
        end
    endtask

    task automatic run8(input logic sel, input logic sub, input logic cin,
                        input logic [7:0] x, input logic [7:0] y,
                        input logic [7:0] es, input logic ec, input logic ev,
                        input string tag);
        int k;
        logic got;
        wait_idle8();
        sel8     = sel;
        s8_sub   = sub;
        s8_cin   = cin;
        s8_x     = x;
        s8_y     = y;
        s8_start = 1'b1;
        step();
        s8_start = 1'b0;
        check({tag, "_busy"}, 32'(busy8), 32'd1);
        k   = 0;
        got = 1'b0;
        while (!got && k < 20) begin
            step();
            k++;
            if (done8) got = 1'b1;
        end
        check({tag, "_lat"}, 32'(k), sel ? 32'd2 : 32'd8);
        check({tag, "_sum"}, 32'(sum8), 32'(es));
        check({tag, "_carry"}, 32'(c8), 32'(ec));
        check({tag, "_ovf"}, 32'(v8), 32'(ev));
        check({tag, "_busy_at_done"}, 32'(busy8), 32'd0);
        step();
        check({tag, "_done_clear"}, 32'(done8), 32'd0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         k;
        int         m;
        logic       seen;
        logic [2:0] got;
        int         lat [3];
        logic [4:0] res [3];
        logic       ovr [3];
        logic [3:0] be;
        logic       c0;
        logic [4:0] full;
        int         sx, sy, sv;
        logic       refv;

        rst_n    = 1'b0;
        s8_start = 1'b0; s8_sub = 1'b0; s8_cin = 1'b0; s8_x = '0; s8_y = '0;
        s4_start = 1'b0; s4_sub = 1'b0; s4_cin = 1'b0; s4_x = '0; s4_y = '0;
        step();
        step();
        check("rst_busy8a", 32'(bus8a.o_busy), 32'd0);
        check("rst_done8a", 32'(bus8a.o_done), 32'd0);
        check("rst_sum8a", 32'(bus8a.o_sum), 32'd0);
        check("rst_carry8a", 32'(bus8a.o_carry), 32'd0);
        check("rst_ovf8a", 32'(bus8a.o_overflow), 32'd0);
        check("rst_sum8b", 32'(bus8b.o_sum), 32'd0);
        check("rst_busy4", 32'({bus4_1.o_busy, bus4_2.o_busy, bus4_4.o_busy}), 32'd0);
        rst_n = 1'b1;
        step();

        // 8-bit, one bit per cycle
        run8(1'b0, 1'b0, 1'b0, 8'd200, 8'd100, 8'd44,  1'b1, 1'b0, "add_200_100");
        run8(1'b0, 1'b0, 1'b0, 8'd100, 8'd100, 8'd200, 1'b0, 1'b1, "add_100_100");
        run8(1'b0, 1'b1, 1'b0, 8'd5,   8'd7,   8'd254, 1'b0, 1'b0, "sub_5_7_b0");
        run8(1'b0, 1'b1, 1'b1, 8'd5,   8'd7,   8'd253, 1'b0, 1'b0, "sub_5_7_b1");
        run8(1'b0, 1'b1, 1'b0, 8'h80,  8'h01,  8'h7F,  1'b1, 1'b1, "sub_80_1");

        // reset held two edges in the middle of a RUN aborts without a done pulse
        wait_idle8();
        sel8     = 1'b0;
        s8_sub   = 1'b0; s8_cin = 1'b0; s8_x = 8'd100; s8_y = 8'd100;
        s8_start = 1'b1;
        step();
        s8_start = 1'b0;
        step();
        step();
        check("midrun_busy_before_rst", 32'(bus8a.o_busy), 32'd1);
        rst_n = 1'b0;
        seen  = 1'b0;
        step();
        if (bus8a.o_done) seen = 1'b1;
        step();
        if (bus8a.o_done) seen = 1'b1;
        check("midrun_rst_busy", 32'(bus8a.o_busy), 32'd0);
        check("midrun_rst_sum", 32'(bus8a.o_sum), 32'd0);
        check("midrun_rst_carry", 32'(bus8a.o_carry), 32'd0);
        check("midrun_rst_ovf", 32'(bus8a.o_overflow), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            if (bus8a.o_done) seen = 1'b1;
        end
        check("midrun_rst_no_done", 32'(seen), 32'd0);
        check("midrun_rst_idle", 32'(bus8a.o_busy), 32'd0);

        // 8-bit, four bits per cycle
        run8(1'b1, 1'b0, 1'b1, 8'd255, 8'd1, 8'd1, 1'b1, 1'b0, "d4_add_255_1_c1");

        // start pulsed mid-RUN with different operands is ignored
        wait_idle8();
        sel8     = 1'b1;
        s8_sub   = 1'b0; s8_cin = 1'b1; s8_x = 8'd255; s8_y = 8'd1;
        s8_start = 1'b1;
        step();
        s8_sub   = 1'b1; s8_cin = 1'b0; s8_x = 8'h12; s8_y = 8'h34;
        step();
        s8_start = 1'b0;
        check("ign_not_done_yet", 32'(bus8b.o_done), 32'd0);
        step();
        check("ign_done", 32'(bus8b.o_done), 32'd1);
        check("ign_sum", 32'(bus8b.o_sum), 32'd1);
        check("ign_carry", 32'(bus8b.o_carry), 32'd1);
        check("ign_ovf", 32'(bus8b.o_overflow), 32'd0);
        step();
        check("ign_no_queue", 32'(bus8b.o_busy), 32'd0);

        // back-to-back: second start during the done cycle
        wait_idle8();
        s8_sub   = 1'b0; s8_cin = 1'b0; s8_x = 8'd3; s8_y = 8'd4;
        s8_start = 1'b1;
        step();
        s8_start = 1'b0;
        k = 0;
        while (!bus8b.o_done && k < 10) begin
            step();
            k++;
        end
        check("b2b_first_lat", 32'(k), 32'd2);
        check("b2b_first_sum", 32'(bus8b.o_sum), 32'd7);
        s8_sub   = 1'b1; s8_cin = 1'b0; s8_x = 8'h50; s8_y = 8'h20;
        s8_start = 1'b1;
        step();
        s8_start = 1'b0;
        check("b2b_second_busy", 32'(bus8b.o_busy), 32'd1);
        m = 1;
        while (!bus8b.o_done && m < 10) begin
            step();
            m++;
        end
        check("b2b_spacing", 32'(m), 32'd3);
        check("b2b_second_sum", 32'(bus8b.o_sum), 32'h30);
        check("b2b_second_carry", 32'(bus8b.o_carry), 32'd1);
        check("b2b_second_ovf", 32'(bus8b.o_overflow), 32'd0);
        step();

        // exhaustive 4-bit sweep, three digit widths in parallel
        for (int sub = 0; sub < 2; sub++) begin
            for (int cin = 0; cin < 2; cin++) begin
                for (int x = 0; x < 16; x++) begin
                    for (int y = 0; y < 16; y++) begin
                        s4_sub   = 1'(sub);
                        s4_cin   = 1'(cin);
                        s4_x     = 4'(x);
                        s4_y     = 4'(y);
                        s4_start = 1'b1;
                        step();
                        s4_start = 1'b0;
                        got = 3'b000;
                        k   = 0;
                        for (int j = 0; j < 3; j++) begin
                            lat[j] = 99; res[j] = '0; ovr[j] = 1'b0;
                        end
                        while (got != 3'b111 && k < 10) begin
                            step();
                            k++;
                            if (!got[0] && bus4_1.o_done) begin
                                got[0] = 1'b1; lat[0] = k;
                                res[0] = {bus4_1.o_carry, bus4_1.o_sum}; ovr[0] = bus4_1.o_overflow;
                            end
                            if (!got[1] && bus4_2.o_done) begin
                                got[1] = 1'b1; lat[1] = k;
                                res[1] = {bus4_2.o_carry, bus4_2.o_sum}; ovr[1] = bus4_2.o_overflow;
                            end
                            if (!got[2] && bus4_4.o_done) begin
                                got[2] = 1'b1; lat[2] = k;
                                res[2] = {bus4_4.o_carry, bus4_4.o_sum}; ovr[2] = bus4_4.o_overflow;
                            end
                        end
                        be   = (sub != 0) ? ~4'(y) : 4'(y);
                        c0   = (sub != 0) ? ~1'(cin) : 1'(cin);
                        full = 5'(x) + {1'b0, be} + {4'b0, c0};
                        sx   = (x > 7) ? x - 16 : x;
                        sy   = (y > 7) ? y - 16 : y;
                        sv   = (sub != 0) ? (sx - sy - cin) : (sx + sy + cin);
                        refv = (sv < -8) || (sv > 7);
                        for (int j = 0; j < 3; j++) begin
                            check($sformatf("sweep_d%0d_lat s%0d c%0d x%0d y%0d", 1 << j, sub, cin, x, y),
                                  32'(lat[j]), 32'(4 >> j));
                            check($sformatf("sweep_d%0d_sum s%0d c%0d x%0d y%0d", 1 << j, sub, cin, x, y),
                                  32'(res[j]), 32'(full));
                            check($sformatf("sweep_d%0d_ovf s%0d c%0d x%0d y%0d", 1 << j, sub, cin, x, y),
                                  32'(ovr[j]), 32'(refv));
                        end
                    end
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
